// File: rtl/i2s_clk_sched.sv
// I2S bit/word clock scheduler: generates bclk/wclk from a shadowed divider and slot
// length, starts on request and stops cleanly at the end of a right slot.
module i2s_clk_sched #(
   parameter int CLK_CNT_W   = 8,
   parameter int BIT_CNT_W   = 5,
   parameter int SAMPLE_SIZE = 24
) (
   input  logic                 adc_clk,
   input  logic                 rst,
   input  logic [CLK_CNT_W-1:0] cfg_div,
   input  logic [BIT_CNT_W-1:0] cfg_slot,
   input  logic                 start,
   input  logic                 stop,
   output logic                 busy,
   output logic                 cfg_err,
   output logic                 i2s_bclk,
   output logic                 i2s_wclk,
   output logic                 sample_stb,
   output logic                 sample_ch,
   output logic                 frame_stb
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [BIT_CNT_W-1:0] SAMPLE_IDX = BIT_CNT_W'(SAMPLE_SIZE);

   // A divider of zero behaves as one so bclk never stalls.
   function automatic logic [CLK_CNT_W-1:0] clamp_div(input logic [CLK_CNT_W-1:0] d);
      clamp_div = (d == {CLK_CNT_W{1'b0}}) ? CLK_CNT_W'(1) : d;
   endfunction

   state_t               state_r;
   logic [CLK_CNT_W-1:0] clk_cnt_r;
   logic [CLK_CNT_W-1:0] div_r;
   logic [BIT_CNT_W-1:0] bit_cnt_r;
   logic [BIT_CNT_W-1:0] slot_r;
   logic                 stop_pend_r;

   logic tick_s;
   logic fall_s;
   logic rise_s;
   logic slot_end_s;
   logic frame_end_s;
   logic sample_hit_s;

   // Edge decode for the current cycle of the bit clock generator.
   always_comb begin
      tick_s       = (clk_cnt_r == (div_r - CLK_CNT_W'(1)));
      fall_s       = tick_s & i2s_bclk;
      rise_s       = tick_s & ~i2s_bclk;
      slot_end_s   = fall_s & (bit_cnt_r == slot_r);
      frame_end_s  = slot_end_s & i2s_wclk;
      sample_hit_s = rise_s & (bit_cnt_r == SAMPLE_IDX);
   end

   // Link state machine with registered clock and strobe outputs.
   always_ff @(posedge adc_clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         clk_cnt_r   <= {CLK_CNT_W{1'b0}};
         div_r       <= {CLK_CNT_W{1'b0}};
         bit_cnt_r   <= {BIT_CNT_W{1'b0}};
         slot_r      <= {BIT_CNT_W{1'b0}};
         stop_pend_r <= 1'b0;
         busy        <= 1'b0;
         cfg_err     <= 1'b0;
         i2s_bclk    <= 1'b0;
         i2s_wclk    <= 1'b0;
         sample_stb  <= 1'b0;
         sample_ch   <= 1'b0;
         frame_stb   <= 1'b0;
      end else begin
         cfg_err    <= 1'b0;
         sample_stb <= 1'b0;
         frame_stb  <= 1'b0;
         case (state_r)
            IDLE: begin
               i2s_bclk  <= 1'b0;
               i2s_wclk  <= 1'b0;
               busy      <= 1'b0;
               sample_ch <= 1'b0;
               if (start) begin
                  if (cfg_slot >= SAMPLE_IDX) begin
                     div_r       <= clamp_div(cfg_div);
                     slot_r      <= cfg_slot;
                     clk_cnt_r   <= {CLK_CNT_W{1'b0}};
                     bit_cnt_r   <= {BIT_CNT_W{1'b0}};
                     stop_pend_r <= 1'b0;
                     busy        <= 1'b1;
                     frame_stb   <= 1'b1;
                     state_r     <= RUN;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            RUN, DRAIN: begin
               if (tick_s) begin
                  clk_cnt_r <= {CLK_CNT_W{1'b0}};
                  i2s_bclk  <= ~i2s_bclk;
               end else begin
                  clk_cnt_r <= clk_cnt_r + CLK_CNT_W'(1);
               end
               // One-bit I2S delay: the LSB of a 24-bit word is clocked at bit index 24.
               if (sample_hit_s) begin
                  sample_stb <= 1'b1;
                  sample_ch  <= i2s_wclk;
               end
               if (fall_s) begin
                  if (slot_end_s) begin
                     bit_cnt_r <= {BIT_CNT_W{1'b0}};
                     i2s_wclk  <= ~i2s_wclk;
                  end else begin
                     bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
                  end
               end
               if (frame_end_s) begin
                  if (stop_pend_r) begin
                     state_r     <= IDLE;
                     busy        <= 1'b0;
                     i2s_bclk    <= 1'b0;
                     i2s_wclk    <= 1'b0;
                     clk_cnt_r   <= {CLK_CNT_W{1'b0}};
                     bit_cnt_r   <= {BIT_CNT_W{1'b0}};
                     stop_pend_r <= 1'b0;
                  end else begin
                     frame_stb <= 1'b1;
                  end
               end
               if ((state_r == RUN) && stop) begin
                  stop_pend_r <= 1'b1;
                  state_r     <= DRAIN;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2s_clk_sched.sv
// Randomized bench for i2s_clk_sched against an arithmetic model that derives every
// output from the cycle count since start, the latched divider and slot length.
module tb_i2s_clk_sched;

   localparam int CW    = 8;
   localparam int BW    = 5;
   localparam int SS    = 24;
   localparam int NEVER = 32'h7fff_ffff;

   logic          adc_clk = 1'b0;
   logic          rst;
   logic [CW-1:0] cfg_div;
   logic [BW-1:0] cfg_slot;
   logic          start;
   logic          stop;
   logic          busy;
   logic          cfg_err;
   logic          i2s_bclk;
   logic          i2s_wclk;
   logic          sample_stb;
   logic          sample_ch;
   logic          frame_stb;

   i2s_clk_sched #(.CLK_CNT_W(CW), .BIT_CNT_W(BW), .SAMPLE_SIZE(SS)) dut (
      .adc_clk    (adc_clk),
      .rst        (rst),
      .cfg_div    (cfg_div),
      .cfg_slot   (cfg_slot),
      .start      (start),
      .stop       (stop),
      .busy       (busy),
      .cfg_err    (cfg_err),
      .i2s_bclk   (i2s_bclk),
      .i2s_wclk   (i2s_wclk),
      .sample_stb (sample_stb),
      .sample_ch  (sample_ch),
      .frame_stb  (frame_stb)
   );

   always #5 adc_clk = ~adc_clk;

   int n_err = 0;
   int n_chk = 0;
   int n_stb = 0;

   // model: running flag, cycles since start edge, latched config, stop end time
   bit m_run = 1'b0;
   int m_c   = 0;
   int m_div = 1;
   int m_slot = 31;
   int m_end = NEVER;
   bit m_err = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   task automatic check_outputs;
      int exp_b, exp_w, exp_s, exp_f, m;
      exp_b = 0; exp_w = 0; exp_s = 0; exp_f = 0;
      if (m_run) begin
         exp_b = (m_c / m_div) % 2;
         exp_w = ((m_c / (2 * m_div)) / (m_slot + 1)) % 2;
         m     = (m_c / m_div) / 2;
         exp_s = ((m_c % m_div) == 0 && ((m_c / m_div) % 2) == 1 && (m % (m_slot + 1)) == SS) ? 1 : 0;
         exp_f = ((m_c % (4 * m_div * (m_slot + 1))) == 0) ? 1 : 0;
      end
      check("busy", {31'd0, busy}, m_run ? 32'd1 : 32'd0);
      check("cfg_err", {31'd0, cfg_err}, m_err ? 32'd1 : 32'd0);
      check("bclk", {31'd0, i2s_bclk}, exp_b);
      check("wclk", {31'd0, i2s_wclk}, exp_w);
      check("sample_stb", {31'd0, sample_stb}, exp_s);
      check("frame_stb", {31'd0, frame_stb}, exp_f);
      if (exp_s == 1) check("sample_ch", {31'd0, sample_ch}, exp_w);
   endtask

   // Drive one cycle of start/stop, advance the model over the edge, then compare.
   task automatic step(input bit st, input bit sp);
      int f, d, sl;
      d  = int'(cfg_div);
      sl = int'(cfg_slot);
      start = st;
      stop  = sp;
      @(posedge adc_clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      m_err = 1'b0;
      if (m_run) begin
         f = 4 * m_div * (m_slot + 1);
         m_c++;
         if (m_c == m_end) m_run = 1'b0;
         else if (sp && m_end == NEVER) m_end = (m_c / f + 1) * f;
      end else if (st) begin
         if (sl >= SS) begin
            m_run  = 1'b1;
            m_c    = 0;
            m_div  = (d == 0) ? 1 : d;
            m_slot = sl;
            m_end  = NEVER;
         end else begin
            m_err = 1'b1;
         end
      end
      if (sample_stb === 1'b1) n_stb++;
      check_outputs();
   endtask

   task automatic drain(input int limit);
      for (int i = 0; i < limit && m_run; i++) step(1'b0, 1'b0);
      check("drain_done", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int lat;
      rst = 1'b0; start = 1'b0; stop = 1'b0;
      cfg_div = 8'd2; cfg_slot = 5'd31;
      #2 rst = 1'b1;
      #1 check_outputs();
      @(posedge adc_clk); #1; rst = 1'b0;

      // defaults: period 4, 256-cycle frame
      step(1'b1, 1'b0);
      for (int i = 0; i < 600; i++) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      drain(1000);

      // divider 0 acts as 1, 25-bit slots
      cfg_div = 8'd0; cfg_slot = 5'd24;
      step(1'b1, 1'b0);
      for (int i = 0; i < 300; i++) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      drain(400);

      // rejected slot length
      cfg_div = 8'd2; cfg_slot = 5'd23;
      step(1'b1, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

      // stop 10 cycles into the left slot completes the frame
      cfg_slot = 5'd31;
      n_stb = 0;
      step(1'b1, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      lat = -1;
      for (int i = 1; i <= 1000; i++) begin
         step(1'b0, 1'b0);
         if (busy === 1'b0) begin
            lat = i;
            break;
         end
      end
      check("stop_latency", lat, 32'd246);
      check("stop_stb_count", n_stb, 32'd2);

      // asynchronous reset in the right slot, then restart
      step(1'b1, 1'b0);
      for (int i = 0; i < 150; i++) step(1'b0, 1'b0);
      #3 rst = 1'b1;
      m_run = 1'b0; m_err = 1'b0;
      #1 check_outputs();
      @(posedge adc_clk); #1; rst = 1'b0;
      step(1'b1, 1'b0);
      for (int i = 0; i < 40; i++) step(1'b0, 1'b0);

      // divider change while busy is ignored until the next start
      cfg_div = 8'd5;
      for (int i = 0; i < 100; i++) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      drain(1000);
      step(1'b1, 1'b0);
      for (int i = 0; i < 200; i++) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      drain(2000);

      // randomized sessions with config churn and sparse start/stop
      for (int s = 0; s < 12; s++) begin
         cfg_div  = CW'($urandom_range(0, 6));
         cfg_slot = BW'($urandom_range(21, 31));
         for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 40) == 0, $urandom_range(0, 300) == 0);
            if ($urandom_range(0, 99) == 0) cfg_div = CW'($urandom_range(0, 6));
            if ($urandom_range(0, 99) == 0) cfg_slot = BW'($urandom_range(21, 31));
         end
      end
      step(1'b0, 1'b1);
      drain(2000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
